maindec_pipe: RTL and testbench

//  Registered, handshaked successor to the combinational main decoder. It decodes a
//  32-bit MIPS instruction into the control bundle and holds it in a one-entry output

---
 rtl/maindec_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_maindec_pipe.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maindec_pipe.sv
// -----------------------------------------------------------------------------
// maindec_pipe
//
// Registered, handshaked MIPS main decoder. An instruction accepted from the
// fetch / IF-ID side is decoded into the control bundle and held in a
// one-entry output register until the ID/EX stage consumes it. The block also
// tracks how long an issued MULT/DIV still needs before HI/LO are valid, and
// refuses to accept instructions that touch HI/LO while that result is pending.
//
// Parameters
//   MUL_LAT  cycles from MULT/MULTU handoff until HI/LO are valid (1..15)
//   DIV_LAT  cycles from DIV/DIVU handoff until HI/LO are valid (1..15)
//   CNT_W    width of the MDU countdown; must hold max(MUL_LAT, DIV_LAT)
//
// Configuration macro
//   MAINDEC_RI_EXC_EN  when defined, illegal opcodes and unsupported SPECIAL
//                      functs decode to an all-zero bundle with ri_exc=1.
//                      When undefined, ri_exc is tied 0 and unknown SPECIAL
//                      functs decode as a plain R-type (regwrite, regdst).
//
// Ports
//   clk         in   clock, rising edge
//   resetn      in   asynchronous reset, active-low
//   in_valid    in   instr is valid
//   in_ready    out  decoder accepts instr this cycle (combinational)
//   instr       in   32-bit instruction, op=[31:26], funct=[5:0]
//   flush       in   kill the held entry (branch/exception redirect)
//   out_valid   out  control bundle valid
//   out_ready   in   ID/EX consumes the bundle
//   regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump
//               out  single-bit control signals
//   hilowe      out  [1]=HI/LO write enable, [0]=source ALU(1)/regfile(0)
//   hilochoose  out  [1]=HI(1)/LO(0), [0]=writeback from HI/LO(1)/normal(0)
//   mdu_busy    out  MDU countdown nonzero
//   ri_exc      out  reserved-instruction flag, qualified by out_valid
// -----------------------------------------------------------------------------
module maindec_pipe #(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 8,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        regwrite,
    output logic        regdst,
    output logic        alusrc,
    output logic        branch,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        jump,
    output logic [1:0]  hilowe,
    output logic [1:0]  hilochoose,
    output logic        mdu_busy,
    output logic        ri_exc
);

    // Opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL functs
    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

    // Field order matches the bundle order seen on the output ports.
    typedef struct packed {
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic       branch;
        logic       memwrite;
        logic       memtoreg;
        logic       jump;
        logic [1:0] hilowe;
        logic [1:0] hilochoose;
    } ctrl_t;

    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_instr_bits;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    // Register/immediate fields are consumed downstream, not here.
    assign unused_instr_bits = ^instr[25:6];

    // -------------------------------------------------------------------------
    // Combinational decode of the offered instruction
    // -------------------------------------------------------------------------
    ctrl_t dec_ctrl;
    logic  dec_hilo;   // touches HI/LO, must wait for a pending MDU result
    logic  dec_mdu;    // starts an MDU operation
    logic  dec_div;    // MDU operation is a divide (longer latency)
`ifdef MAINDEC_RI_EXC_EN
    logic  dec_ri;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default before the case, so no
        // path through it can leave a value unassigned and infer a latch.
        dec_ctrl = '0;
        dec_hilo = 1'b0;
        dec_mdu  = 1'b0;
        dec_div  = 1'b0;
`ifdef MAINDEC_RI_EXC_EN
        dec_ri   = 1'b0;
`endif
        unique case (op)
            OP_SPECIAL: begin
                unique case (funct)
                    F_MFHI: begin
                        dec_ctrl.regwrite   = 1'b1;
                        dec_ctrl.regdst     = 1'b1;
                        dec_ctrl.hilochoose = 2'b11;
                        dec_hilo            = 1'b1;
                    end
                    F_MFLO: begin
                        dec_ctrl.regwrite   = 1'b1;
                        dec_ctrl.regdst     = 1'b1;
                        dec_ctrl.hilochoose = 2'b01;
                        dec_hilo            = 1'b1;
                    end
                    F_MTHI, F_MTLO: begin
                        dec_ctrl.hilowe = 2'b10;
                        dec_hilo        = 1'b1;
                    end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        dec_ctrl.regwrite = 1'b1;
                        dec_ctrl.regdst   = 1'b1;
                        dec_ctrl.hilowe   = 2'b11;
                        dec_hilo          = 1'b1;
                        dec_mdu           = 1'b1;
                        dec_div           = (funct == F_DIV) || (funct == F_DIVU);
                    end
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                    F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
                    F_JR: begin
                        dec_ctrl.regwrite = 1'b1;
                        dec_ctrl.regdst   = 1'b1;
                    end
                    default: begin
`ifdef MAINDEC_RI_EXC_EN
                        dec_ri = 1'b1;
`else
                        // Unknown functs fall back to a plain R-type.
                        dec_ctrl.regwrite = 1'b1;
                        dec_ctrl.regdst   = 1'b1;
`endif
                    end
                endcase
            end
            OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
                dec_ctrl.regwrite = 1'b1;
                dec_ctrl.alusrc   = 1'b1;
                dec_ctrl.memtoreg = 1'b1;
            end
            OP_SW, OP_SH, OP_SB: begin
                dec_ctrl.alusrc   = 1'b1;
                dec_ctrl.memwrite = 1'b1;
            end
            OP_BEQ: begin
                dec_ctrl.branch = 1'b1;
            end
            OP_J: begin
                dec_ctrl.jump = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
            OP_LUI: begin
                dec_ctrl.regwrite = 1'b1;
                dec_ctrl.alusrc   = 1'b1;
            end
            default: begin
`ifdef MAINDEC_RI_EXC_EN
                dec_ri = 1'b1;
`endif
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Handshake, hazard and MDU countdown
    // -------------------------------------------------------------------------
    logic             out_valid_q, out_valid_d;
    ctrl_t            ctrl_q,      ctrl_d;
    logic             held_mdu_q,  held_mdu_d;
    logic             held_div_q,  held_div_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
`ifdef MAINDEC_RI_EXC_EN
    logic             ri_q,        ri_d;
`endif

    logic hazard;
    logic accept;
    logic handoff;

    // A HI/LO user must wait while a result is still counting down, and also
    // while an MDU op sits in the output register: its countdown only starts
    // once ID/EX takes it. The counter is used as registered, so the cycle in
    // which it reads 0 is already a legal accept cycle.
    assign hazard   = ((cnt_q != '0) || (out_valid_q && held_mdu_q)) && dec_hilo;
    assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid_q && out_ready && !flush;

    always_comb begin
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        held_mdu_d  = held_mdu_q;
        held_div_d  = held_div_q;
        cnt_d       = cnt_q;
`ifdef MAINDEC_RI_EXC_EN
        ri_d        = ri_q;
`endif

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            // Also covers handoff-and-accept in the same cycle: the new entry
            // simply replaces the one leaving.
            out_valid_d = 1'b1;
            ctrl_d      = dec_ctrl;
            held_mdu_d  = dec_mdu;
            held_div_d  = dec_div;
`ifdef MAINDEC_RI_EXC_EN
            ri_d        = dec_ri;
`endif
        end else if (handoff) begin
            out_valid_d = 1'b0;
        end

        // A flushed MDU op never issued, so it must not start a countdown; an
        // op that already issued keeps counting regardless of flush.
        if (handoff && held_mdu_q) begin
            cnt_d = held_div_q ? DIV_CNT : MUL_CNT;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            held_mdu_q  <= 1'b0;
            held_div_q  <= 1'b0;
            cnt_q       <= '0;
`ifdef MAINDEC_RI_EXC_EN
            ri_q        <= 1'b0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // register samples the pre-edge values computed above.
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            held_mdu_q  <= held_mdu_d;
            held_div_q  <= held_div_d;
            cnt_q       <= cnt_d;
`ifdef MAINDEC_RI_EXC_EN
            ri_q        <= ri_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign out_valid  = out_valid_q;
    assign regwrite   = ctrl_q.regwrite;
    assign regdst     = ctrl_q.regdst;
    assign alusrc     = ctrl_q.alusrc;
    assign branch     = ctrl_q.branch;
    assign memwrite   = ctrl_q.memwrite;
    assign memtoreg   = ctrl_q.memtoreg;
    assign jump       = ctrl_q.jump;
    assign hilowe     = ctrl_q.hilowe;
    assign hilochoose = ctrl_q.hilochoose;
    assign mdu_busy   = (cnt_q != '0);

`ifdef MAINDEC_RI_EXC_EN
    assign ri_exc = ri_q && out_valid_q;
`else
    assign ri_exc = 1'b0;
`endif

endmodule

// File: tb/tb_maindec_pipe.sv
// -----------------------------------------------------------------------------
// tb_maindec_pipe
//
// Self-checking bench for maindec_pipe. A cycle-level reference model keeps the
// held entry and the absolute cycle at which the pending MDU result becomes
// valid; the bundle comes from a table written straight from the instruction
// encodings. Directed sequences cover reset, streaming, back-pressure, the DIV
// stall window, flush of a held MULT and the reserved-instruction case, then a
// randomized run exercises everything together.
// -----------------------------------------------------------------------------
module tb_maindec_pipe;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 8;
    localparam int CNT_W   = 4;

`ifdef MAINDEC_RI_EXC_EN
    localparam bit RI_EN = 1'b1;
`else
    localparam bit RI_EN = 1'b0;
`endif

    typedef enum int {K_PLAIN, K_HILO, K_MUL, K_DIV} kind_e;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump;
    logic [1:0]  hilowe;
    logic [1:0]  hilochoose;
    logic        mdu_busy;
    logic        ri_exc;

    maindec_pipe #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .alusrc     (alusrc),
        .branch     (branch),
        .memwrite   (memwrite),
        .memtoreg   (memtoreg),
        .jump       (jump),
        .hilowe     (hilowe),
        .hilochoose (hilochoose),
        .mdu_busy   (mdu_busy),
        .ri_exc     (ri_exc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] bundle_now();
        return {regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump, hilowe, hilochoose};
    endfunction

    // ---------------------------------------------------------------- model
    function automatic void ref_decode(input logic [31:0] ins, output logic [10:0] b,
                                       output bit ri, output kind_e kind);
        logic [5:0] op;
        logic [5:0] fn;
        op   = ins[31:26];
        fn   = ins[5:0];
        b    = 11'b00000000000;
        ri   = 1'b0;
        kind = K_PLAIN;
        if (op == 6'h00) begin
            if (fn == 6'h10) begin b = 11'b11000000011; kind = K_HILO; end
            else if (fn == 6'h12) begin b = 11'b11000000001; kind = K_HILO; end
            else if (fn == 6'h11 || fn == 6'h13) begin b = 11'b00000001000; kind = K_HILO; end
            else if (fn == 6'h18 || fn == 6'h19) begin b = 11'b11000001100; kind = K_MUL; end
            else if (fn == 6'h1A || fn == 6'h1B) begin b = 11'b11000001100; kind = K_DIV; end
            else if ((fn >= 6'h20 && fn <= 6'h27) || fn == 6'h2A || fn == 6'h2B ||
                     fn == 6'h00 || fn == 6'h02 || fn == 6'h03 || fn == 6'h04 ||
                     fn == 6'h06 || fn == 6'h07 || fn == 6'h08)
                b = 11'b11000000000;
            else if (RI_EN) ri = 1'b1;
            else b = 11'b11000000000;
        end else if (op == 6'h23 || op == 6'h21 || op == 6'h25 || op == 6'h20 || op == 6'h24)
            b = 11'b10100100000;
        else if (op == 6'h2B || op == 6'h29 || op == 6'h28)
            b = 11'b00101000000;
        else if (op == 6'h04)
            b = 11'b00010000000;
        else if (op == 6'h02)
            b = 11'b00000010000;
        else if (op >= 6'h08 && op <= 6'h0F)
            b = 11'b10100000000;
        else
            ri = RI_EN;
    endfunction

    bit          m_valid;
    logic [10:0] m_bundle;
    bit          m_ri;
    kind_e       m_kind;
    int          cyc;
    int          busy_until;   // first cycle at which the MDU result is valid

    function automatic void model_reset();
        m_valid    = 1'b0;
        m_bundle   = '0;
        m_ri       = 1'b0;
        m_kind     = K_PLAIN;
        cyc        = 0;
        busy_until = 0;
    endfunction

    // One clock cycle: drive at the falling edge, check outputs and in_ready,
    // then advance the model to the state after the next rising edge.
    task automatic step(input bit iv, input logic [31:0] ins, input bit fl, input bit ordy,
                        output bit accepted);
        logic [10:0] b;
        bit          ri;
        kind_e       kind;
        bit          busy, hz, rdy, handoff;
        @(negedge clk);
        in_valid  = iv;
        instr     = ins;
        flush     = fl;
        out_ready = ordy;
        #1;
        busy = (cyc < busy_until);
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        check("mdu_busy", {31'd0, mdu_busy}, {31'd0, busy});
        if (m_valid) begin
            check("bundle", {21'd0, bundle_now()}, {21'd0, m_bundle});
            check("ri_exc", {31'd0, ri_exc}, {31'd0, m_ri});
        end
        ref_decode(ins, b, ri, kind);
        hz  = (busy || (m_valid && (m_kind == K_MUL || m_kind == K_DIV))) && (kind != K_PLAIN);
        rdy = (!m_valid || ordy) && !hz && !fl;
        check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        accepted = iv && rdy;
        handoff  = m_valid && ordy && !fl;
        if (handoff && m_kind == K_MUL) busy_until = cyc + 1 + MUL_LAT;
        if (handoff && m_kind == K_DIV) busy_until = cyc + 1 + DIV_LAT;
        if (fl) m_valid = 1'b0;
        else if (accepted) begin
            m_valid  = 1'b1;
            m_bundle = b;
            m_ri     = ri;
            m_kind   = kind;
        end else if (handoff) m_valid = 1'b0;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn    = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        instr     = '0;
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
    endtask

    // Instruction generator biased toward the interesting classes.
    logic [5:0] op_pool [22] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h21, 6'h25, 6'h20,
                                 6'h24, 6'h2B, 6'h29, 6'h28, 6'h04, 6'h02, 6'h08, 6'h09,
                                 6'h0D, 6'h0F, 6'h3F, 6'h01, 6'h05, 6'h1C};
    logic [5:0] fn_pool [24] = '{6'h10, 6'h12, 6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B,
                                 6'h10, 6'h12, 6'h20, 6'h21, 6'h22, 6'h24, 6'h27, 6'h2A,
                                 6'h00, 6'h03, 6'h07, 6'h08, 6'h01, 6'h3F, 6'h09, 6'h05};

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        r = $urandom();
        return {op_pool[$urandom_range(0, 21)], r[19:0], fn_pool[$urandom_range(0, 23)]};
    endfunction

    localparam logic [31:0] I_LW   = {6'h23, 26'h0A4_0004};
    localparam logic [31:0] I_ADDI = {6'h08, 26'h021_0005};
    localparam logic [31:0] I_BEQ  = {6'h04, 26'h022_0003};
    localparam logic [31:0] I_SW   = {6'h2B, 26'h0A6_0008};
    localparam logic [31:0] I_DIV  = {6'h00, 20'h43000, 6'h1A};
    localparam logic [31:0] I_MULT = {6'h00, 20'h43000, 6'h18};
    localparam logic [31:0] I_MFLO = {6'h00, 20'h00028, 6'h12};
    localparam logic [31:0] I_MFHI = {6'h00, 20'h00028, 6'h10};
    localparam logic [31:0] I_ILL  = {6'h3F, 26'h0};

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        int stalls;
        int busy_cycles;
        bit got_it;

        resetn    = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        instr     = '0;
        model_reset();
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_bundle", {21'd0, bundle_now()}, 32'd0);
        check("reset_mdu_busy", {31'd0, mdu_busy}, 32'd0);
        check("reset_ri_exc", {31'd0, ri_exc}, 32'd0);
        do_reset();

        // Streaming LW, ADDI, BEQ at one per cycle.
        step(1'b1, I_LW, 1'b0, 1'b1, acc);
        step(1'b1, I_ADDI, 1'b0, 1'b1, acc);
        check("stream_lw", {21'd0, bundle_now()}, {21'd0, 11'b10100100000});
        step(1'b1, I_BEQ, 1'b0, 1'b1, acc);
        check("stream_addi", {21'd0, bundle_now()}, {21'd0, 11'b10100000000});
        step(1'b0, I_LW, 1'b0, 1'b1, acc);
        check("stream_beq", {21'd0, bundle_now()}, {21'd0, 11'b00010000000});

        // SW held under back-pressure for 3 cycles.
        step(1'b1, I_SW, 1'b0, 1'b1, acc);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, I_ADDI, 1'b0, 1'b0, acc);
            check("hold_sw", {21'd0, bundle_now()}, {21'd0, 11'b00101000000});
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        step(1'b0, I_ADDI, 1'b0, 1'b1, acc);

        // DIV handoff, then MFLO offered until it is taken.
        do_reset();
        step(1'b1, I_DIV, 1'b0, 1'b1, acc);
        step(1'b0, I_DIV, 1'b0, 1'b1, acc);
        stalls      = 0;
        busy_cycles = 0;
        got_it      = 1'b0;
        for (int i = 0; i < 40 && !got_it; i++) begin
            step(1'b1, I_MFLO, 1'b0, 1'b1, acc);
            if (mdu_busy) busy_cycles++;
            if (acc) got_it = 1'b1;
            else stalls++;
        end
        check("div_accept", {31'd0, got_it}, 32'd1);
        check("div_stalls", stalls, DIV_LAT);
        check("div_busy", busy_cycles, DIV_LAT);
        step(1'b0, I_MFLO, 1'b0, 1'b0, acc);
        check("mflo_bundle", {21'd0, bundle_now()}, {21'd0, 11'b11000000001});

        // MULT held, then flushed: no countdown, MFHI accepted right after.
        do_reset();
        step(1'b1, I_MULT, 1'b0, 1'b0, acc);
        step(1'b0, I_MULT, 1'b1, 1'b1, acc);
        step(1'b1, I_MFHI, 1'b0, 1'b1, acc);
        check("flush_mdu_busy", {31'd0, mdu_busy}, 32'd0);
        check("flush_mfhi_acc", {31'd0, acc}, 32'd1);
        step(1'b0, I_MFHI, 1'b0, 1'b1, acc);

        // Illegal opcode.
        step(1'b1, I_ILL, 1'b0, 1'b0, acc);
        step(1'b0, I_ILL, 1'b0, 1'b0, acc);
        check("ill_bundle", {21'd0, bundle_now()}, 32'd0);
        check("ill_ri_exc", {31'd0, ri_exc}, {31'd0, RI_EN});
        step(1'b0, I_ILL, 1'b0, 1'b1, acc);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7, gen_instr(), $urandom_range(0, 11) == 0,
                 $urandom_range(0, 9) < 7, acc);
        end

        // Reset mid-stream with an entry held and a countdown running.
        do_reset();
        step(1'b1, I_DIV, 1'b0, 1'b1, acc);
        step(1'b1, I_LW, 1'b0, 1'b1, acc);
        step(1'b0, I_LW, 1'b0, 1'b0, acc);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_bundle", {21'd0, bundle_now()}, 32'd0);
        check("midrst_mdu_busy", {31'd0, mdu_busy}, 32'd0);
        check("midrst_ri_exc", {31'd0, ri_exc}, 32'd0);
        in_valid = 1'b0;
        instr    = I_MFHI;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("postrst_in_ready", {31'd0, in_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
